// File: rtl/apb_irq_pkg.sv
// Shared register map constants and helpers for the APB interrupt controller.
package apb_irq_pkg;

    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_STATUS  = 3'd1;
    localparam logic [2:0] REG_MASK    = 3'd2;
    localparam logic [2:0] REG_MODE    = 3'd3;
    localparam logic [2:0] REG_PENDING = 3'd4;
    localparam logic [2:0] REG_VECTOR  = 3'd5;
    localparam logic [2:0] REG_SWSET   = 3'd6;

    localparam int unsigned VECTOR_VALID_BIT = 31;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [4:0] lowest_set_idx(input logic [31:0] vec);
        logic [4:0] idx;
        idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) idx = 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_src_cell.sv
// One interrupt source: input synchroniser, edge/level event detection and STATUS bit.
module irq_src_cell #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic pclk_i,
    input  logic rst_n_i,
    input  logic irq_i,
    input  logic edge_mode_i,
    input  logic gen_i,
    input  logic swset_i,
    input  logic w1c_i,
    output logic status_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   status_q;
    logic                   status_d;
    logic                   sync;
    logic                   ev;

    assign sync = sync_q[SYNC_STAGES-1];
    assign ev   = edge_mode_i ? (sync & ~prev_q) : sync;

    // A set request wins over a simultaneous clear so no event is lost.
    always_comb begin
        status_d = status_q;
        if (gen_i && (ev || swset_i)) begin
            status_d = 1'b1;
        end else if (w1c_i) begin
            status_d = 1'b0;
        end
    end

    always_ff @(posedge pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q   <= '0;
            prev_q   <= 1'b0;
            status_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], irq_i};
            prev_q   <= sync;
            status_q <= status_d;
        end
    end

    assign status_o = status_q;

endmodule

// File: rtl/apb_irq_ctrl_n.sv
// APB interrupt controller: register decode, mask/mode/enable and vector priority encoder.
module apb_irq_ctrl_n
    import apb_irq_pkg::*;
#(
    parameter int unsigned NUM_IRQ     = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned IDX_W       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               pclk_i,
    input  logic               rst_n_i,
    input  logic               psel_i,
    input  logic               penable_i,
    input  logic               pwrite_i,
    input  logic [31:0]        paddr_i,
    input  logic [31:0]        pwdata_i,
    output logic [31:0]        prdata_o,
    output logic               pready_o,
    output logic               pslverr_o,
    input  logic [NUM_IRQ-1:0] irq_request_i,
    output logic               interrupt_o
);

    logic [2:0]         reg_idx;
    logic               apb_access;
    logic               apb_wr;
    logic               apb_setup_rd;
    logic               gen_q;
    logic [NUM_IRQ-1:0] mask_q;
    logic [NUM_IRQ-1:0] mode_q;
    logic [NUM_IRQ-1:0] status;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] w1c;
    logic [NUM_IRQ-1:0] swset;
    logic [4:0]         idx_full;
    logic [31:0]        vector_val;
    logic [31:0]        rdata;
    logic [31:0]        prdata_q;
    logic               irq_q;
    logic               unused_bits;

    assign reg_idx      = paddr_i[4:2];
    assign apb_access   = psel_i & penable_i;
    assign apb_wr       = apb_access & pwrite_i;
    assign apb_setup_rd = psel_i & ~penable_i & ~pwrite_i;
    assign unused_bits  = ^{paddr_i[31:5], paddr_i[1:0], pwdata_i, idx_full};

    assign pready_o  = 1'b1;
    assign pslverr_o = apb_access & ((reg_idx == 3'd7) |
                       (pwrite_i & ((reg_idx == REG_PENDING) | (reg_idx == REG_VECTOR))));

    assign w1c   = (apb_wr && reg_idx == REG_STATUS) ? pwdata_i[NUM_IRQ-1:0] : '0;
    assign swset = (apb_wr && reg_idx == REG_SWSET)  ? pwdata_i[NUM_IRQ-1:0] : '0;

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_src
        irq_src_cell #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_src (
            .pclk_i      (pclk_i),
            .rst_n_i     (rst_n_i),
            .irq_i       (irq_request_i[i]),
            .edge_mode_i (mode_q[i]),
            .gen_i       (gen_q),
            .swset_i     (swset[i]),
            .w1c_i       (w1c[i]),
            .status_o    (status[i])
        );
    end

    assign pending  = status & mask_q;
    assign idx_full = lowest_set_idx(32'(pending));

    always_comb begin
        vector_val                   = '0;
        vector_val[VECTOR_VALID_BIT] = |pending;
        vector_val[IDX_W-1:0]        = idx_full[IDX_W-1:0];
    end

    always_comb begin
        rdata = '0;
        case (reg_idx)
            REG_CTRL:    rdata = {31'd0, gen_q};
            REG_STATUS:  rdata = 32'(status);
            REG_MASK:    rdata = 32'(mask_q);
            REG_MODE:    rdata = 32'(mode_q);
            REG_PENDING: rdata = 32'(pending);
            REG_VECTOR:  rdata = vector_val;
            default:     rdata = '0;
        endcase
    end

    always_ff @(posedge pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            gen_q    <= 1'b0;
            mask_q   <= '0;
            mode_q   <= '0;
            prdata_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            if (apb_wr) begin
                case (reg_idx)
                    REG_CTRL: gen_q  <= pwdata_i[0];
                    REG_MASK: mask_q <= pwdata_i[NUM_IRQ-1:0];
                    REG_MODE: mode_q <= pwdata_i[NUM_IRQ-1:0];
                    default:  ;
                endcase
            end
            if (apb_setup_rd) prdata_q <= rdata;
            irq_q <= gen_q & (|pending);
        end
    end

    assign prdata_o    = prdata_q;
    assign interrupt_o = irq_q;

endmodule

// File: doc/apb_irq_ctrl_n.md
Name: apb_irq_ctrl_n

Overview:
Parametrised APB interrupt controller, the successor to the 4-source status/clear/mask controller.
- Aggregates NUM_IRQ asynchronous request lines into one interrupt output.
- Adds per-source edge/level mode, input synchronisation, software trigger, global enable and a lowest-index-first vector register.
- Sits on the peripheral APB bus between peripheral IRQ sources and the CPU interrupt input.

Parameters:
NUM_IRQ, 8, number of request lines; legal range 1..32
SYNC_STAGES, 2, synchroniser flops per request line; must be >= 2
IDX_W, $clog2(NUM_IRQ) (min 1), width of the vector index field

Ports:
pclk_i  in  1  single clock for APB and all controller logic
rst_n_i  in  1  reset, asynchronous assert, active-low
psel_i  in  1  APB select
penable_i  in  1  APB enable (access phase)
pwrite_i  in  1  APB write, 1 = write
paddr_i  in  32  APB byte address; only [4:2] decoded
pwdata_i  in  32  APB write data
prdata_o  out  32  APB read data, registered
pready_o  out  1  APB ready; tied to 1 (zero wait states)
pslverr_o  out  1  APB error
irq_request_i  in  NUM_IRQ  asynchronous request lines, active-high
interrupt_o  out  1  registered interrupt to CPU, active-high

Behaviour:
- Reset: all registers 0; prdata_o=0, pslverr_o=0, interrupt_o=0. pready_o=1 always, including during reset.
- APB write commits on psel_i & penable_i & pwrite_i.
- APB read: prdata_o is loaded in the setup phase (psel_i & ~penable_i & ~pwrite_i) and is valid during the access phase. Otherwise prdata_o holds its value.
- Register map (paddr_i[4:2]):
  - 0 CTRL: bit0 GEN global enable, RW.
  - 1 STATUS: raw pending; write-1-to-clear.
  - 2 MASK: RW, 1 = enabled.
  - 3 MODE: RW, 1 = edge, 0 = level.
  - 4 PENDING: STATUS & MASK, RO.
  - 5 VECTOR: RO; bit31 VALID, [IDX_W-1:0] index of lowest-numbered PENDING bit; all zero when none.
  - 6 SWSET: write-1-to-set STATUS, reads 0.
  - 7: unmapped.
- Register widths: bits >= NUM_IRQ in STATUS/MASK/MODE/PENDING read 0 and ignore writes.
- pslverr_o = 1 in the access phase for:
  - any access to index 7;
  - a write to index 4 or 5 (no state change).
  - 0 otherwise.
  - pslverr_o is combinational on the access phase.
- Synchroniser: each irq_request_i bit passes through SYNC_STAGES flops giving sync[i]. prev[i] <= sync[i] every cycle, regardless of mode or GEN.
- Event per bit, each cycle:
  - Edge mode: ev = sync & ~prev.
  - Level mode: ev = sync.
  - Software: swset = SWSET write with pwdata_i[i] = 1.
- STATUS[i] next state, in priority order:
  - GEN=0: hold; events and swset are ignored, W1C still clears.
  - (ev | swset) = 1: STATUS set. Set beats a simultaneous W1C, so no event is lost.
  - W1C bit = 1: STATUS cleared.
  - otherwise: hold.
- Level-mode consequence: W1C has no lasting effect while the line stays high; the bit re-sets on the next cycle.
- MODE change: no spurious edge is generated, because prev always tracks sync.
- Latency:
  - Input rising at cycle 0 → STATUS set after SYNC_STAGES+1 edges.
  - interrupt_o = registered (GEN & |PENDING), +1 cycle.
  - W1C of the last pending bit drops interrupt_o 2 edges after the write commits.
- Masking affects only PENDING, VECTOR and interrupt_o. Masked sources still latch in STATUS.
- VECTOR is computed combinationally from PENDING and captured via prdata_o. Ties resolve to the lowest index.
- Reset mid-operation (async) clears everything immediately, including synchroniser and prev. A line that is still high after reset appears as a rising edge once synchronised.

Decomposition:
- Package apb_irq_pkg holds:
  - register index constants (CTRL=0 … SWSET=6);
  - VECTOR_VALID_BIT=31;
  - a function computing the lowest-set-bit index.
- One sub-module: irq_src_cell, per-source synchroniser + prev + edge/level event + STATUS flop. It is instantiated NUM_IRQ times with a generate loop.
- Top level holds the APB decode, CTRL/MASK/MODE registers, priority encoder and the interrupt_o flop.

Test Plan:
1. Reset, then read all 7 registers → all 0. Access index 7 → pslverr_o=1 and prdata_o=0.
2. GEN=1, MASK=0xFF, MODE=0xFF; pulse irq_request_i[3] high for 1 cycle:
   - STATUS=0x08 after 3 edges; interrupt_o=1 one edge later.
   - VECTOR=0x8000_0003.
   - W1C 0x08 → interrupt_o=0 after 2 edges.
3. Level mode, irq[5] held high:
   - W1C 0x20 → STATUS reads 0x20 again.
   - Deassert irq[5], then W1C → STATUS=0, interrupt_o=0.
4. Edge mode, irq[0] and irq[6] rise in the same cycle, MASK=0x40 → STATUS=0x41, PENDING=0x40, VECTOR=0x8000_0006.
5. GEN=0, SWSET 0x04 and pulse irq[1] → STATUS unchanged, interrupt_o=0. Then GEN=1, SWSET 0x04 → STATUS=0x04.
6. Edge mode, irq[2] rises in the same cycle a W1C 0x04 commits → STATUS[2]=1 (set wins). Write PENDING → pslverr_o=1, no change.
